// File: rtl/dff_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_test_pkg
// Description : Shared types, constants and helpers for the DFF test readout
//               path: FSM state encoding, frame geometry and the popcount used
//               to build the frame checksum field.
// Revision    : 1.0 - initial release
// ============================================================================
package dff_test_pkg;

    // Readout sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int         FRAME_W        = 32;
    localparam int         NUM_DFF        = 19;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         POP_W          = 5;

    // Number of set bits in a DFF snapshot. With 19 inputs the maximum is 19,
    // which fits the 5-bit field without overflow.
    function automatic logic [POP_W-1:0] popcount(input logic [NUM_DFF-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_DFF; i++) begin
            cnt = cnt + {{(POP_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det (plus vector variant sync_vec)
// Description : sync_vec    - WIDTH-bit, SYNC_STAGES-deep synchronizer for
//                             asynchronous inputs.
//               sync_edge_det - 1-bit synchronizer followed by a rising-edge
//                             detector built from one extra delay flop.
// Ports       : clk     - sampling clock
//               rst     - synchronous active-high reset (clears every flop)
//               i_d     - asynchronous input
//               o_q / o_sync - synchronized level
//               o_rise  - one-cycle pulse on a synchronized 0->1 transition
// Revision    : 1.0 - initial release
// ============================================================================
module sync_vec #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Stage 0 is the metastability-catching flop; the last stage is the
    // first one safe to use in logic.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise
);

    logic w_sync;
    logic r_dly;

    sync_vec #(
        .WIDTH       (1),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_d),
        .o_q (w_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly <= 1'b0;
        end else begin
            r_dly <= w_sync;
        end
    end

    // Combinational pulse so the consumer reacts on the edge right after the
    // synchronized level rises (pin-to-action = SYNC_STAGES + 1 cycles).
    assign o_sync = w_sync;
    assign o_rise = w_sync & ~r_dly;

endmodule
`default_nettype wire

// File: rtl/dff_capture_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dff_capture_shift_ctrl
// Description : Snapshots the test chip's DFF Q outputs on a Raspberry Pi save
//               request and shifts a 32-bit frame {HEADER, Q[18:0],
//               popcount(Q)} out MSB first, one bit per Pi data-clock edge.
// Ports       : CLK_50M       in   1   system clock (only clock)
//               RST           in   1   synchronous active-high reset
//               dffq_in       in   19  DFF Q pins (async)
//               save_data_pi  in   1   capture request level (async)
//               data_clk_pi   in   1   Pi shift clock, sampled (async)
//               data_out_pi   out  1   serial frame bit
//               busy          out  1   high in CAPTURE/SHIFT/DONE
//               capture_count out  16  completed captures, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module dff_capture_shift_ctrl
    import dff_test_pkg::*;
#(
    parameter int         NUM_BITS    = NUM_DFF,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] HEADER      = HEADER_DEFAULT
) (
    input  logic                CLK_50M,
    input  logic                RST,
    input  logic [NUM_BITS-1:0] dffq_in,
    input  logic                save_data_pi,
    input  logic                data_clk_pi,
    output logic                data_out_pi,
    output logic                busy,
    output logic [15:0]         capture_count
);

    localparam int IDX_W = $clog2(FRAME_W);

    logic [NUM_BITS-1:0] w_dffq_sync;
    logic                w_save_sync;
    logic                w_save_rise;
    logic                w_dclk_sync;
    logic                w_dclk_rise;
    logic [FRAME_W-1:0]  w_frame;

    state_t              r_state;
    logic [NUM_BITS-1:0] r_shadow;
    logic [FRAME_W-1:0]  r_shift;
    logic [IDX_W-1:0]    r_bit_idx;
    logic                r_data_out;
    logic                r_busy;
    logic [15:0]         r_count;

    sync_vec #(
        .WIDTH       (NUM_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_dffq (
        .clk (CLK_50M),
        .rst (RST),
        .i_d (dffq_in),
        .o_q (w_dffq_sync)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_save (
        .clk    (CLK_50M),
        .rst    (RST),
        .i_d    (save_data_pi),
        .o_sync (w_save_sync),
        .o_rise (w_save_rise)
    );

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_dclk (
        .clk    (CLK_50M),
        .rst    (RST),
        .i_d    (data_clk_pi),
        .o_sync (w_dclk_sync),
        .o_rise (w_dclk_rise)
    );

    // The frame is assembled from the same synchronized value that lands in
    // the shadow register during CAPTURE, so the shift register and shadow
    // always describe the identical snapshot.
    assign w_frame = {HEADER, w_dffq_sync, popcount(w_dffq_sync)};

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_shadow   <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_data_out <= 1'b0;
            r_busy     <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // data_clk edges are deliberately ignored here, which also
                    // resolves a coincident save/data_clk edge in favour of save.
                    r_data_out <= 1'b0;
                    if (w_save_rise) begin
                        r_state <= ST_CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    r_shadow   <= w_dffq_sync;
                    r_shift    <= w_frame;
                    r_data_out <= w_frame[FRAME_W-1];
                    r_bit_idx  <= '0;
                    r_count    <= r_count + 16'd1;
                    r_state    <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    // The Pi samples before raising data_clk, so each edge
                    // retires the bit currently presented.
                    if (w_dclk_rise) begin
                        r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                        if (r_bit_idx == IDX_W'(FRAME_W-1)) begin
                            r_data_out <= 1'b0;
                            r_state    <= ST_DONE;
                        end else begin
                            r_data_out <= r_shift[FRAME_W-2];
                        end
                    end
                end

                ST_DONE: begin
                    // Waiting for save to drop keeps a held-high request from
                    // producing a second frame.
                    r_data_out <= 1'b0;
                    if (!w_save_sync) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_data_out <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign data_out_pi   = r_data_out;
    assign busy          = r_busy;
    assign capture_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dff_capture_shift_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dff_capture_shift_ctrl
// Description : Directed self-checking bench for dff_capture_shift_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_capture_shift_ctrl;

    logic        r_clk  = 1'b0;
    logic        r_rst  = 1'b1;
    logic [18:0] r_dffq = '0;
    logic        r_save = 1'b0;
    logic        r_dclk = 1'b0;
    logic        w_data_out;
    logic        w_busy;
    logic [15:0] w_count;

    int n_pass  = 0;
    int n_total = 0;

    dff_capture_shift_ctrl dut (
        .CLK_50M       (r_clk),
        .RST           (r_rst),
        .dffq_in       (r_dffq),
        .save_data_pi  (r_save),
        .data_clk_pi   (r_dclk),
        .data_out_pi   (w_data_out),
        .busy          (w_busy),
        .capture_count (w_count)
    );

    always #10 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, act, exp);
    endtask

    // Raise save and verify the SYNC_STAGES+1 latency to busy; returns #1
    // after the edge that enters SHIFT with the first bit presented.
    task automatic start_capture(input string tag);
        @(negedge r_clk);
        r_save = 1'b1;
        repeat (2) @(posedge r_clk);
        #1 check({tag, "_busy_lat_lo"}, 32'(w_busy), 32'd0);
        @(posedge r_clk);
        #1 check({tag, "_busy_lat_hi"}, 32'(w_busy), 32'd1);
        @(posedge r_clk);
        #1;
    endtask

    // Slow Pi: sample, raise data_clk for 4 cycles, lower for 4 cycles.
    task automatic read_bits(input int n, output logic [31:0] f);
        f = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge r_clk);
            f = {f[30:0], w_data_out};
            r_dclk = 1'b1;
            repeat (4) @(negedge r_clk);
            r_dclk = 1'b0;
            repeat (3) @(negedge r_clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 10 && w_busy; k++) begin
            @(posedge r_clk);
            #1;
        end
        check({tag, "_idle"}, 32'(w_busy), 32'd0);
    endtask

    task automatic drop_save_and_idle(input string tag);
        @(negedge r_clk);
        r_save = 1'b0;
        wait_idle(tag);
    endtask

    logic [31:0] v_frame;

    initial begin
        // Reset state
        repeat (3) @(posedge r_clk);
        @(negedge r_clk);
        r_rst = 1'b0;
        @(posedge r_clk);
        #1;
        check("rst_dout",  32'(w_data_out), 32'd0);
        check("rst_busy",  32'(w_busy),     32'd0);
        check("rst_count", 32'(w_count),    32'd0);

        // Basic frame 19'h55555, save held to DONE
        r_dffq = 19'h55555;
        repeat (4) @(posedge r_clk);
        start_capture("f55555");
        read_bits(32, v_frame);
        check("f55555_frame", v_frame, 32'hA5AAAAAA);
        check("f55555_count", 32'(w_count), 32'd1);
        check("f55555_done_dout", 32'(w_data_out), 32'd0);
        drop_save_and_idle("f55555");

        // All ones
        r_dffq = 19'h7FFFF;
        repeat (4) @(posedge r_clk);
        start_capture("f7ffff");
        read_bits(32, v_frame);
        check("f7ffff_frame", v_frame, 32'hA5FFFFF3);
        check("f7ffff_count", 32'(w_count), 32'd2);
        drop_save_and_idle("f7ffff");

        // All zeros, with save released early: DONE lasts one cycle
        r_dffq = 19'h00000;
        repeat (4) @(posedge r_clk);
        start_capture("f00000");
        @(negedge r_clk);
        r_save = 1'b0;
        read_bits(32, v_frame);
        check("f00000_frame", v_frame, 32'hA5000000);
        check("f00000_busy_after", 32'(w_busy), 32'd0);
        check("f00000_count", 32'(w_count), 32'd3);

        // Inputs change during SHIFT: snapshot must be preserved
        r_dffq = 19'h12345;
        repeat (4) @(posedge r_clk);
        start_capture("f12345");
        r_dffq = 19'h7FFFF;
        read_bits(32, v_frame);
        check("f12345_frame", v_frame, 32'hA52468A7);
        drop_save_and_idle("f12345");

        // Save held high through frame and DONE: exactly one capture
        start_capture("held");
        read_bits(32, v_frame);
        check("held_frame", v_frame, 32'hA5FFFFF3);
        repeat (12) @(posedge r_clk);
        #1;
        check("held_busy_done", 32'(w_busy),  32'd1);
        check("held_count",     32'(w_count), 32'd5);
        check("held_dout",      32'(w_data_out), 32'd0);
        drop_save_and_idle("held");
        repeat (6) @(posedge r_clk);
        #1;
        check("held_no_retrig", 32'(w_busy),  32'd0);
        check("held_count2",    32'(w_count), 32'd5);

        // Reset mid-SHIFT
        r_dffq = 19'h55555;
        start_capture("rstmid");
        check("rstmid_count", 32'(w_count), 32'd6);
        read_bits(4, v_frame);
        check("rstmid_partial", v_frame, 32'h0000000A);
        @(negedge r_clk);
        r_rst  = 1'b1;
        r_save = 1'b0;
        repeat (3) @(posedge r_clk);
        #1;
        check("rstmid_dout",  32'(w_data_out), 32'd0);
        check("rstmid_busy",  32'(w_busy),     32'd0);
        check("rstmid_count", 32'(w_count),    32'd0);
        @(negedge r_clk);
        r_rst = 1'b0;
        repeat (6) @(posedge r_clk);
        #1;
        check("rstmid_post_busy", 32'(w_busy), 32'd0);

        // data_clk edges in IDLE are ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge r_clk);
            r_dclk = 1'b1;
            repeat (4) @(negedge r_clk);
            r_dclk = 1'b0;
            repeat (4) @(posedge r_clk);
            #1;
            check($sformatf("idle_dclk%0d_dout", i), 32'(w_data_out), 32'd0);
            check($sformatf("idle_dclk%0d_busy", i), 32'(w_busy),     32'd0);
        end

        // Counter wrap
        @(negedge r_clk);
        force dut.r_count = 16'hFFFF;
        @(posedge r_clk);
        #1 release dut.r_count;
        r_dffq = 19'h40001;
        repeat (4) @(posedge r_clk);
        start_capture("wrap");
        check("wrap_count", 32'(w_count), 32'd0);
        read_bits(32, v_frame);
        check("wrap_frame", v_frame, 32'hA5800022);
        drop_save_and_idle("wrap");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
